// File: rtl/wb_timer_multi.sv
`timescale 1ns/1ps
// wb_timer_multi
// Multi-channel compare/auto-reload timer on a 32-bit Wishbone slave port,
// with a general-purpose output register and a synchronised input register.
//
// Optional feature macro: WB_TIMER_MULTI_PRESCALER_EN
//   defined   -> 16-bit PRESCALE register at 0x108; channels advance once every
//                PRESCALE+1 clocks
//   undefined -> channels advance every clock; 0x108 reads 0, writes ignored
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   wb_adr_i[8:2]      register address (adr[8]=0 channel region, 1 global)
//   wb_dat_i/wb_dat_o  write / read data
//   wb_sel_i           byte selects
//   wb_stb_i/wb_cyc_i  strobe / cycle
//   wb_we_i            write enable
//   wb_ack_o           single-cycle acknowledge
//   intr[NUM_CH]       per-channel level interrupt (TRIG & IRQEN, registered)
//   gpo[GPO_W]         general-purpose outputs
//   gpi[GPI_W]         asynchronous general-purpose inputs
module wb_timer_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int GPO_W  = 8,
    parameter int GPI_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic              wb_we_i,
    output logic              wb_ack_o,
    output logic [NUM_CH-1:0] intr,
    output logic [GPO_W-1:0]  gpo,
    input  logic [GPI_W-1:0]  gpi
);

    logic [NUM_CH-1:0] en, ar, irqen, trig, match;
    logic [NUM_CH-1:0] tcr_wr, cmp_wr, cnt_wr;
    logic [CNT_W-1:0]  compare [NUM_CH];
    logic [CNT_W-1:0]  counter [NUM_CH];
    logic [GPI_W-1:0]  gpi_s1, gpi_s2;
    logic [31:0]       rdata;
    logic              req, wr_en, is_glob, gpo_wr, tick;
    logic [3:0]        ch_sel;
    logic [1:0]        reg_sel;
    logic              unused_adr;

    // Replace only the selected bytes of a register image.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[b*8 +: 8] = sel[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        return res;
    endfunction

    // A new request is one not already being acknowledged; writes take
    // effect in the ack cycle while the master still holds the bus.
    assign req        = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_en      = wb_ack_o & wb_stb_i & wb_cyc_i & wb_we_i;
    assign is_glob    = wb_adr_i[8];
    assign ch_sel     = wb_adr_i[7:4];
    assign reg_sel    = wb_adr_i[3:2];
    assign gpo_wr     = wr_en & is_glob & (reg_sel == 2'd0);
    assign unused_adr = &{1'b0, wb_adr_i[31:9], wb_adr_i[1:0]};

    // Per-channel write strobes; channels at or above NUM_CH never match.
    always_comb begin
        tcr_wr = '0;
        cmp_wr = '0;
        cnt_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && !is_glob && ch_sel == 4'(i)) begin
                tcr_wr[i] = (reg_sel == 2'd0) && wb_sel_i[0];
                cmp_wr[i] = (reg_sel == 2'd1);
                cnt_wr[i] = (reg_sel == 2'd2);
            end
        end
    end

`ifdef WB_TIMER_MULTI_PRESCALER_EN
    logic [15:0] prescale, pre_cnt;
    logic        pre_wr;

    assign pre_wr = wr_en & is_glob & (reg_sel == 2'd2);
    assign tick   = (pre_cnt == prescale);

    // Free-running divider; a PRESCALE write restarts the phase at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else if (pre_wr) begin
            prescale <= 16'(byte_merge(32'(prescale), wb_dat_i, wb_sel_i));
            pre_cnt  <= '0;
        end else begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            match[i] = tick & en[i] & (counter[i] == compare[i]);
    end

    // Channel state. A match setting TRIG wins over a W1C in the same cycle,
    // and a software COUNTER write wins over increment/reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            en    <= '0;
            ar    <= '0;
            irqen <= '0;
            trig  <= '0;
            intr  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                compare[i] <= '0;
                counter[i] <= '0;
            end
        end else begin
            intr <= trig & irqen;
            for (int i = 0; i < NUM_CH; i++) begin
                if (tcr_wr[i]) begin
                    en[i]    <= wb_dat_i[0];
                    ar[i]    <= wb_dat_i[1];
                    irqen[i] <= wb_dat_i[2];
                end else if (match[i] && !ar[i]) begin
                    en[i] <= 1'b0;
                end

                if (match[i])
                    trig[i] <= 1'b1;
                else if (tcr_wr[i] && wb_dat_i[3])
                    trig[i] <= 1'b0;

                if (cmp_wr[i])
                    compare[i] <= CNT_W'(byte_merge(32'(compare[i]), wb_dat_i, wb_sel_i));

                if (cnt_wr[i])
                    counter[i] <= CNT_W'(byte_merge(32'(counter[i]), wb_dat_i, wb_sel_i));
                else if (match[i]) begin
                    if (ar[i])
                        counter[i] <= '0;
                end else if (tick && en[i])
                    counter[i] <= counter[i] + CNT_W'(1);
            end
        end
    end

    // GPO register and two-flop input synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            gpo    <= '0;
            gpi_s1 <= '0;
            gpi_s2 <= '0;
        end else begin
            gpi_s1 <= gpi;
            gpi_s2 <= gpi_s1;
            if (gpo_wr)
                gpo <= GPO_W'(byte_merge(32'(gpo), wb_dat_i, wb_sel_i));
        end
    end

    // Read multiplexer; anything unmapped reads as zero.
    always_comb begin
        rdata = '0;
        if (!is_glob) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == 4'(i)) begin
                    case (reg_sel)
                        2'd0:    rdata = {28'd0, trig[i], irqen[i], ar[i], en[i]};
                        2'd1:    rdata = 32'(compare[i]);
                        2'd2:    rdata = 32'(counter[i]);
                        default: rdata = '0;
                    endcase
                end
            end
        end else begin
            case (reg_sel)
                2'd0:    rdata = 32'(gpo);
                2'd1:    rdata = 32'(gpi_s2);
`ifdef WB_TIMER_MULTI_PRESCALER_EN
                2'd2:    rdata = 32'(prescale);
`else
                2'd2:    rdata = '0;
`endif
                default: rdata = 32'(NUM_CH);
            endcase
        end
    end

    // Read data is captured with the request so it is valid alongside ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rdata : 32'd0;
        end
    end

endmodule
